// File: rtl/regbus_pkg.sv
// regbus_pkg: arbiter FSM states and register-bus field widths shared with the decode generator
package regbus_pkg;
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;
    localparam int C_NUM_REQ_DEF    = 2;
    localparam int C_ADDR_WIDTH_DEF = 10;
    localparam int C_DATA_WIDTH_DEF = 32;
    localparam int C_TIMEOUT_DEF    = 16;
endpackage

// File: rtl/regbus_rr_pick.sv
// regbus_rr_pick: combinational round-robin pick, first request after ptr wins
module regbus_rr_pick #(
    parameter int N = 2
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] idx,
    output logic                 any
);
    localparam int IW = $clog2(N);
    int best;
    // distance from ptr+1 going upwards modulo N; smallest distance wins
    always_comb begin
        idx  = '0;
        best = N;
        for (int j = 0; j < N; j++) begin
            if (req[j] && ((j + N - 1 - int'(ptr)) % N) < best) begin
                best = (j + N - 1 - int'(ptr)) % N;
                idx  = IW'(j);
            end
        end
    end
    assign any = |req;
    assign gnt = any ? N'(1) << idx : '0;
endmodule

// File: rtl/regbus_arbiter.sv
// regbus_arbiter: round-robin share of one pulse req/ack register port among requesters,
// one transaction in flight, ack timeout reported as an error completion
module regbus_arbiter
    import regbus_pkg::*;
#(
    parameter int C_NUM_REQ    = C_NUM_REQ_DEF,
    parameter int C_ADDR_WIDTH = C_ADDR_WIDTH_DEF,
    parameter int C_DATA_WIDTH = C_DATA_WIDTH_DEF,
    parameter int C_TIMEOUT    = C_TIMEOUT_DEF
) (
    input  logic                                     aclk,
    input  logic                                     areset,
    input  logic [C_NUM_REQ-1:0]                     s_req,
    input  logic [C_NUM_REQ-1:0]                     s_we,
    input  logic [C_NUM_REQ*C_ADDR_WIDTH-1:0]        s_addr,
    input  logic [C_NUM_REQ*C_DATA_WIDTH-1:0]        s_wdata,
    input  logic [C_NUM_REQ*(C_DATA_WIDTH/8)-1:0]    s_be,
    output logic [C_NUM_REQ-1:0]                     s_ack,
    output logic                                     s_err,
    output logic [C_DATA_WIDTH-1:0]                  s_rdata,
    output logic                                     m_req,
    output logic                                     m_we,
    output logic [C_ADDR_WIDTH-1:0]                  m_addr,
    output logic [C_DATA_WIDTH-1:0]                  m_wdata,
    output logic [C_DATA_WIDTH/8-1:0]                m_be,
    input  logic                                     m_ack,
    input  logic [C_DATA_WIDTH-1:0]                  m_rdata
);
    localparam int N  = C_NUM_REQ;
    localparam int AW = C_ADDR_WIDTH;
    localparam int DW = C_DATA_WIDTH;
    localparam int BW = DW / 8;
    localparam int IW = $clog2(N);
    localparam int CW = $clog2(C_TIMEOUT + 1);
    state_t          state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   pick_idx;
    logic [N-1:0]    pick_gnt;
    logic            pick_any;
    logic [N-1:0]    grant;
    logic [CW-1:0]   cnt;
    logic            sel_we;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_wdata;
    logic [BW-1:0]   sel_be;
    regbus_rr_pick #(.N(N)) u_pick (
        .req (s_req),
        .ptr (ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_be    = '0;
        for (int j = 0; j < N; j++) begin
            if (pick_gnt[j]) begin
                sel_we    = s_we[j];
                sel_addr  = s_addr[j*AW +: AW];
                sel_wdata = s_wdata[j*DW +: DW];
                sel_be    = s_be[j*BW +: BW];
            end
        end
    end
    // cnt reaches 1 at the end of the m_req cycle; an m_ack on the timeout cycle still wins
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state   <= S_IDLE;
            ptr     <= IW'(N - 1);
            grant   <= '0;
            cnt     <= '0;
            m_req   <= 1'b0;
            m_we    <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            m_be    <= '0;
            s_ack   <= '0;
            s_err   <= 1'b0;
            s_rdata <= '0;
        end else begin
            m_req   <= 1'b0;
            s_ack   <= '0;
            s_err   <= 1'b0;
            s_rdata <= '0;
            cnt     <= '0;
            case (state)
                S_IDLE: begin
                    if (pick_any) begin
                        state   <= S_WAIT;
                        ptr     <= pick_idx;
                        grant   <= pick_gnt;
                        m_req   <= 1'b1;
                        m_we    <= sel_we;
                        m_addr  <= sel_addr;
                        m_wdata <= sel_wdata;
                        m_be    <= sel_be;
                    end
                end
                S_WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (m_ack || cnt == CW'(C_TIMEOUT)) begin
                        state   <= S_DONE;
                        cnt     <= '0;
                        s_ack   <= grant;
                        s_err   <= !m_ack;
                        s_rdata <= (m_ack && !m_we) ? m_rdata : '0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_regbus_arbiter.sv
// tb_regbus_arbiter: directed scenarios plus randomized traffic against a timestamp-based
// transaction model of the arbiter
module tb_regbus_arbiter;
    localparam int N  = 2;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int TO = 16;

    logic              aclk = 1'b0;
    logic              areset = 1'b1;
    logic [N-1:0]      s_req = '0;
    logic [N-1:0]      s_we = '0;
    logic [N*AW-1:0]   s_addr = '0;
    logic [N*DW-1:0]   s_wdata = '0;
    logic [N*BW-1:0]   s_be = '0;
    logic [N-1:0]      s_ack;
    logic              s_err;
    logic [DW-1:0]     s_rdata;
    logic              m_req;
    logic              m_we;
    logic [AW-1:0]     m_addr;
    logic [DW-1:0]     m_wdata;
    logic [BW-1:0]     m_be;
    logic              m_ack = 1'b0;
    logic [DW-1:0]     m_rdata = '0;

    regbus_arbiter #(.C_NUM_REQ(N), .C_ADDR_WIDTH(AW), .C_DATA_WIDTH(DW), .C_TIMEOUT(TO)) dut (
        .aclk(aclk), .areset(areset), .s_req(s_req), .s_we(s_we), .s_addr(s_addr),
        .s_wdata(s_wdata), .s_be(s_be), .s_ack(s_ack), .s_err(s_err), .s_rdata(s_rdata),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
        .m_ack(m_ack), .m_rdata(m_rdata)
    );

    always #5 aclk = ~aclk;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int last_c = 0;

    logic [N-1:0]  pend = '0;
    logic [N-1:0]  drop = '0;
    logic          f_we [N];
    logic [AW-1:0] f_addr [N];
    logic [DW-1:0] f_wdata [N];
    logic [BW-1:0] f_be [N];
    bit            persist = 0;
    bit            rand_mode = 0;
    bit            force_ack = 0;
    int            ack_delay = 1;
    int            ack_at = -1;
    logic [DW-1:0] rdata_val = '0;

    bit            busy;
    int            t0, done_at, mg, mptr;
    logic          e_mreq, e_we, e_err;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata, e_rdata;
    logic [BW-1:0] e_be;
    logic [N-1:0]  e_sack;

    logic [N-1:0]  o_sack;
    logic          o_err, o_mreq, o_mwe;
    logic [DW-1:0] o_rdata, o_mwdata;
    logic [AW-1:0] o_maddr;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s (cycle %0d): got %0h, expected %0h", nm, cyc, act, exp);
    endtask

    task automatic model_reset();
        busy = 0; done_at = -1; mptr = N - 1; mg = 0;
        e_mreq = 0; e_we = 0; e_err = 0; e_addr = '0; e_wdata = '0; e_rdata = '0; e_be = '0; e_sack = '0;
    endtask

    // transaction timestamps: arbitration at t0, m_req at t0+1, completion registered one cycle later
    task automatic model_step();
        int w;
        e_mreq = 0; e_sack = '0; e_err = 0; e_rdata = '0;
        if (!busy) begin
            if (s_req != '0) begin
                w = -1;
                for (int k = 1; k <= N; k++)
                    if (w < 0 && ((s_req >> ((mptr + k) % N)) & N'(1)) != '0) w = (mptr + k) % N;
                busy = 1; t0 = cyc; done_at = -1; mg = w; mptr = w;
                e_mreq = 1; e_we = f_we[w]; e_addr = f_addr[w]; e_wdata = f_wdata[w]; e_be = f_be[w];
            end
        end else if (done_at < 0) begin
            if (m_ack) begin
                done_at = cyc; e_sack = N'(1) << mg; e_rdata = e_we ? '0 : m_rdata;
            end else if (cyc - t0 - 1 == TO) begin
                done_at = cyc; e_sack = N'(1) << mg; e_err = 1;
            end
        end else busy = 0;
    endtask

    task automatic sample_check();
        @(negedge aclk);
        o_sack = s_ack; o_err = s_err; o_rdata = s_rdata; o_mreq = m_req;
        o_mwe = m_we; o_maddr = m_addr; o_mwdata = m_wdata;
        chk("m_req", m_req, e_mreq);
        chk("m_we", m_we, e_we);
        chk("m_addr", m_addr, e_addr);
        chk("m_wdata", m_wdata, e_wdata);
        chk("m_be", m_be, e_be);
        chk("s_ack", s_ack, e_sack);
        chk("s_err", s_err, e_err);
        chk("s_rdata", s_rdata, e_rdata);
    endtask

    task automatic run_cycle();
        bit spur;
        sample_check();
        last_c = cyc;
        for (int i = 0; i < N; i++) begin
            if (o_sack[i]) begin
                pend[i] = persist; drop[i] = 0;
            end
        end
        spur = 0;
        if (rand_mode) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 3) == 0) begin
                    pend[i] = 1; f_we[i] = 1'($urandom); f_addr[i] = AW'($urandom);
                    f_wdata[i] = $urandom; f_be[i] = BW'($urandom);
                end else if (pend[i] && $urandom_range(0, 7) == 0) begin
                    f_addr[i] = AW'($urandom); f_wdata[i] = $urandom; f_we[i] = 1'($urandom);
                end
                if (pend[i] && $urandom_range(0, 15) == 0) drop[i] = ~drop[i];
            end
            if (o_mreq) ack_at = cyc + (($urandom_range(0, 3) == 0) ? $urandom_range(1, TO + 3) : $urandom_range(1, 3));
            spur = ($urandom_range(0, 19) == 0);
            m_rdata = $urandom;
        end else begin
            if (o_mreq) ack_at = (ack_delay < 0) ? -1 : cyc + ack_delay;
            m_rdata = rdata_val;
        end
        m_ack = force_ack || (cyc == ack_at) || spur;
        if (m_ack && o_mwe) begin
            wr_addr = o_maddr; wr_data = o_mwdata;
        end
        for (int i = 0; i < N; i++) begin
            s_req[i] = pend[i] & ~drop[i];
            s_we[i] = f_we[i];
            s_addr[i*AW +: AW] = f_addr[i];
            s_wdata[i*DW +: DW] = f_wdata[i];
            s_be[i*BW +: BW] = f_be[i];
        end
        model_step();
        cyc++;
    endtask

    task automatic do_reset();
        areset = 1; pend = '0; drop = '0; persist = 0; force_ack = 0; ack_at = -1;
        s_req = '0; m_ack = 0;
        model_reset();
        sample_check();
        sample_check();
        areset = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b, tack, ng, pm;
        for (int i = 0; i < N; i++) begin
            f_we[i] = 0; f_addr[i] = '0; f_wdata[i] = '0; f_be[i] = '1;
        end
        model_reset();

        // single read
        do_reset();
        ack_delay = 1; rdata_val = 32'hCAFE_0001;
        pend[0] = 1; f_we[0] = 0; f_addr[0] = 10'h001;
        run_cycle();
        run_cycle();
        chk("t1 m_req cycle1", o_mreq, 1);
        chk("t1 m_addr", o_maddr, 10'h001);
        run_cycle();
        run_cycle();
        chk("t1 s_ack cycle3", o_sack, 2'b01);
        chk("t1 s_rdata", o_rdata, 32'hCAFE_0001);
        chk("t1 s_err", o_err, 0);

        // both requesting, alternating grants
        do_reset();
        persist = 1; ack_delay = 1; pend = '1; ng = 0; pm = -1;
        for (int i = 0; i < 40 && ng < 6; i++) begin
            run_cycle();
            if (o_mreq) begin
                if (pm >= 0) chk("t2 m_req spacing", last_c - pm, 4);
                pm = last_c;
            end
            if (o_sack != '0) begin
                chk("t2 grant order", o_sack, (ng % 2) ? 2'b10 : 2'b01);
                ng++;
            end
        end
        chk("t2 grants done", ng, 6);
        persist = 0; pend = '0;
        repeat (6) run_cycle();

        // write timeout then late ack
        ack_delay = -1; rdata_val = 32'h5555_AAAA;
        pend[1] = 1; f_we[1] = 1; f_addr[1] = 10'h3F0; f_wdata[1] = 32'h0BAD_F00D;
        b = cyc; tack = -1;
        for (int i = 0; i < 30 && tack < 0; i++) begin
            run_cycle();
            if (o_sack != '0) begin
                tack = last_c - b;
                chk("t3 s_ack", o_sack, 2'b10);
                chk("t3 s_err", o_err, 1);
                chk("t3 s_rdata", o_rdata, 0);
            end
        end
        chk("t3 timeout cycle", tack, 18);
        force_ack = 1;
        run_cycle();
        run_cycle();
        force_ack = 0;
        run_cycle();
        chk("t3 late ack ignored", o_sack, 0);
        run_cycle();

        // ack on the timeout cycle wins
        ack_delay = 16; rdata_val = 32'h1234_5678;
        pend[0] = 1; f_we[0] = 0; f_addr[0] = 10'h0AA;
        b = cyc; tack = -1;
        for (int i = 0; i < 30 && tack < 0; i++) begin
            run_cycle();
            if (o_sack != '0) begin
                tack = last_c - b;
                chk("t4 s_err", o_err, 0);
                chk("t4 s_rdata", o_rdata, 32'h1234_5678);
            end
        end
        chk("t4 ack cycle", tack, 18);
        run_cycle();

        // reset during a wait; requester 0 wins afterwards
        ack_delay = -1;
        pend[0] = 1; f_we[0] = 1; f_addr[0] = 10'h3C3; f_wdata[0] = 32'h7777_0005;
        run_cycle();
        run_cycle();
        chk("t5 m_req before reset", o_mreq, 1);
        #2;
        areset = 1;
        #1;
        chk("t5 m_req in reset", m_req, 0);
        chk("t5 m_addr in reset", m_addr, 0);
        chk("t5 s_ack in reset", s_ack, 0);
        do_reset();
        ack_delay = 1; pend = '1; tack = -1;
        for (int i = 0; i < 10 && tack < 0; i++) begin
            run_cycle();
            if (o_sack != '0) begin
                tack = last_c;
                chk("t5 first winner", o_sack, 2'b01);
            end
        end
        chk("t5 completed", tack >= 0, 1);
        pend = '0;
        repeat (6) run_cycle();

        // fields changed after grant are not seen
        ack_delay = 4; rdata_val = 32'hFFFF_FFFF;
        pend[1] = 1; f_we[1] = 1; f_addr[1] = 10'h055; f_wdata[1] = 32'hA5A5_0006; f_be[1] = 4'hF;
        run_cycle();
        f_addr[1] = 10'h2AA; f_wdata[1] = 32'hDEAD_BEEF; f_be[1] = 4'h1;
        run_cycle();
        chk("t6 m_addr latched", o_maddr, 10'h055);
        chk("t6 m_wdata latched", o_mwdata, 32'hA5A5_0006);
        tack = -1; wr_addr = '0; wr_data = '0;
        for (int i = 0; i < 10 && tack < 0; i++) begin
            run_cycle();
            if (o_sack != '0) begin
                tack = last_c;
                chk("t6 s_rdata on write", o_rdata, 0);
            end
        end
        chk("t6 written addr", wr_addr, 10'h055);
        chk("t6 written data", wr_data, 32'hA5A5_0006);
        pend = '0;
        repeat (4) run_cycle();

        // randomized traffic
        do_reset();
        rand_mode = 1;
        repeat (2000) run_cycle();
        rand_mode = 0; pend = '0; drop = '0; ack_delay = 2;
        repeat (30) run_cycle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
